ifu_fetch: RTL

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 116 +++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit with redirect, halt and fault handling
module ifu_fetch #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [XLEN-1:0]       imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  input  logic                  imem_resp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [XLEN-1:0]       inst_pc,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  input  logic                  halt,
  output logic                  fetch_fault,
  output logic [XLEN-1:0]       current_pc,
  output logic [63:0]           fetch_count
);
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;
  logic [1:0]            state;
  logic [XLEN-1:0]       pc;
  logic [XLEN-1:0]       instPcReg;
  logic [INST_WIDTH-1:0] instReg;
  logic                  drop;
  logic                  haltPend;
  logic                  fault;
  logic [63:0]           count;
  logic                  misaligned;
  assign misaligned     = redirect_valid && (redirect_pc[1:0] != 2'b00);
  // A request is withheld whenever a redirect or halt would change where fetch goes next
  assign imem_req_valid = (state == ST_REQ) && !redirect_valid && !halt && !rst;
  assign inst_valid     = (state == ST_HOLD) && !rst;
  assign imem_req_addr  = pc;
  assign current_pc     = pc;
  assign inst           = instReg;
  assign inst_pc        = instPcReg;
  assign fetch_fault    = fault;
  assign fetch_count    = count;
  // Fetch sequencing; halt outranks redirect, and a misaligned redirect target faults
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_REQ;
      pc        <= RESET_PC;
      instReg   <= '0;
      instPcReg <= '0;
      drop      <= 1'b0;
      haltPend  <= 1'b0;
      fault     <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          if (halt) state <= ST_HALT;
          else if (redirect_valid) begin
            pc <= redirect_pc;
            if (misaligned) begin
              fault <= 1'b1;
              state <= ST_HALT;
            end
          end else if (imem_req_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (halt || haltPend) begin
            haltPend <= 1'b1;
            if (imem_resp_valid) state <= ST_HALT;
          end else if (redirect_valid) begin
            pc <= redirect_pc;
            if (misaligned) begin
              fault <= 1'b1;
              state <= ST_HALT;
            end else if (imem_resp_valid) begin
              drop  <= 1'b0;
              state <= ST_REQ;
            end else drop <= 1'b1;
          end else if (imem_resp_valid) begin
            drop <= 1'b0;
            if (drop) state <= ST_REQ;
            else if (imem_resp_err) begin
              fault <= 1'b1;
              state <= ST_HALT;
            end else begin
              instReg   <= imem_resp_data;
              instPcReg <= pc;
              state     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (inst_ready) count <= count + 64'd1;
          if (halt) begin
            if (inst_ready) pc <= pc + XLEN'(4);
            state <= ST_HALT;
          end else if (redirect_valid) begin
            pc    <= redirect_pc;
            fault <= misaligned;
            state <= misaligned ? ST_HALT : ST_REQ;
          end else if (inst_ready) begin
            pc    <= pc + XLEN'(4);
            state <= ST_REQ;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
